// File: rtl/fc_pkg.sv
// Shared types, constants and helpers for the fully-connected layer sequencer.
package fc_pkg;

    localparam int unsigned ACC_W    = 32;
    localparam int          INT8_MIN = -128;
    localparam int          INT8_MAX = 127;

    typedef logic signed [7:0] int8_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_IN = 3'd1,
        ST_BIAS    = 3'd2,
        ST_MAC     = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_EMIT    = 3'd5
    } fc_seq_state_t;

    // Clamp a wide signed accumulator into the int8 range.
    function automatic int8_t sat_int8(input logic signed [ACC_W-1:0] x);
        if (x > INT8_MAX) begin
            return 8'(INT8_MAX);
        end else if (x < INT8_MIN) begin
            return 8'(INT8_MIN);
        end
        return 8'(x);
    endfunction

endpackage

// File: rtl/fc_mac_unit.sv
// Single signed 8x8 MAC with bias preload and int8 output stage.
// FC_SEQ_SATURATE_EN selects clamping instead of modulo-256 wrap.
module fc_mac_unit
    import fc_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  i_clr,
    input  logic  i_load_bias,
    input  logic  i_acc,
    input  int8_t i_bias,
    input  int8_t i_act,
    input  int8_t i_wgt,
    output int8_t o_result_c
);

    logic signed [15:0]      w_prod;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] r_acc;

    assign w_prod = 16'(i_act) * 16'(i_wgt);
    assign w_sum  = r_acc + ACC_W'(w_prod);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_load_bias) begin
            r_acc <= ACC_W'(i_bias);
        end else if (i_acc) begin
            r_acc <= w_sum;
        end
    end

    // Result includes the product being added this cycle so DRAIN needs no extra stage.
`ifdef FC_SEQ_SATURATE_EN
    assign o_result_c = sat_int8(w_sum);
`else
    assign o_result_c = w_sum[7:0];
`endif

endmodule

// File: rtl/fc_layer_sequencer.sv
// Time-multiplexed FC layer: buffers the input vector, then runs one MAC per neuron.
// Build option FC_SEQ_SATURATE_EN (in fc_mac_unit) clamps results instead of wrapping.
module fc_layer_sequencer
    import fc_pkg::*;
#(
    parameter int unsigned INPUT_SIZE  = 128,
    parameter int unsigned OUTPUT_SIZE = 10,
    parameter int unsigned W_ADDR_W    = 11,
    parameter int unsigned B_ADDR_W    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                busy,
    input  logic                in_valid,
    input  logic [7:0]          in_data,
    output logic                in_ready,
    output logic                w_rd_en,
    output logic [W_ADDR_W-1:0] w_addr,
    input  logic [7:0]          w_data,
    output logic                b_rd_en,
    output logic [B_ADDR_W-1:0] b_addr,
    input  logic [7:0]          b_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [7:0]          out_data,
    output logic [B_ADDR_W-1:0] out_index,
    output logic                done
);

    localparam int unsigned J_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
    localparam logic [J_W-1:0]      LAST_J = J_W'(INPUT_SIZE - 1);
    localparam logic [B_ADDR_W-1:0] LAST_I = B_ADDR_W'(OUTPUT_SIZE - 1);

    fc_seq_state_t       r_state;
    logic [J_W-1:0]      r_j;
    logic [B_ADDR_W-1:0] r_i;
    int8_t               r_a;
    int8_t               r_buf [INPUT_SIZE];

    logic  w_mac_clr;
    logic  w_mac_load;
    logic  w_mac_acc;
    int8_t w_mac_result;

    // Input buffer: contents are don't-care after reset, so no reset branch.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            r_buf[r_j] <= in_data;
        end
    end

    // MAC cycle 0 loads the bias; later cycles and DRAIN add the delayed product.
    assign w_mac_clr  = (r_state == ST_IDLE);
    assign w_mac_load = (r_state == ST_MAC) && (r_j == '0);
    assign w_mac_acc  = ((r_state == ST_MAC) && (r_j != '0)) || (r_state == ST_DRAIN);

    fc_mac_unit u_mac (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (w_mac_clr),
        .i_load_bias (w_mac_load),
        .i_acc       (w_mac_acc),
        .i_bias      (b_data),
        .i_act       (r_a),
        .i_wgt       (w_data),
        .o_result_c  (w_mac_result)
    );

    // Sequencer: outputs are set on the transition into the state that owns them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_j       <= '0;
            r_i       <= '0;
            r_a       <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
            w_rd_en   <= 1'b0;
            w_addr    <= '0;
            b_rd_en   <= 1'b0;
            b_addr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state  <= ST_LOAD_IN;
                        r_j      <= '0;
                        r_i      <= '0;
                        busy     <= 1'b1;
                        in_ready <= 1'b1;
                    end
                end
                ST_LOAD_IN: begin
                    if (in_valid && in_ready) begin
                        if (r_j == LAST_J) begin
                            r_state  <= ST_BIAS;
                            in_ready <= 1'b0;
                            r_i      <= '0;
                            b_rd_en  <= 1'b1;
                            b_addr   <= '0;
                        end else begin
                            r_j <= r_j + 1'b1;
                        end
                    end
                end
                ST_BIAS: begin
                    r_state <= ST_MAC;
                    r_j     <= '0;
                    b_rd_en <= 1'b0;
                    w_rd_en <= 1'b1;
                    w_addr  <= W_ADDR_W'(r_i * INPUT_SIZE);
                end
                ST_MAC: begin
                    // r_a lines up with the weight returned one cycle later.
                    r_a <= r_buf[r_j];
                    if (r_j == LAST_J) begin
                        r_state <= ST_DRAIN;
                        w_rd_en <= 1'b0;
                    end else begin
                        r_j    <= r_j + 1'b1;
                        w_addr <= w_addr + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    r_state   <= ST_EMIT;
                    out_data  <= w_mac_result;
                    out_index <= r_i;
                    out_valid <= 1'b1;
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (r_i == LAST_I) begin
                            r_state <= ST_IDLE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            r_state <= ST_BIAS;
                            r_i     <= r_i + 1'b1;
                            b_addr  <= r_i + 1'b1;
                            b_rd_en <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
